icache_refill_ctrl: RTL and testbench

//  AHB-lite read master that refills one I-cache line on a miss. Accepts a miss address,

---
 rtl/icache_refill_if.sv | 54 +++++
 rtl/icache_refill_ctrl.sv | 166 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_if.sv
// icache_refill_if
//   Groups the signals between the I-cache refill controller and its neighbours:
//   the miss request handshake from the cache miss logic, the AHB-lite read
//   master bus, and the beat write port into the cache data array.
//
//   Handshake rule for miss_valid/miss_ready: a request transfers on a rising
//   clock edge where both are high. The requester keeps miss_valid high and
//   miss_addr stable until that edge. miss_ready does not depend on
//   miss_valid. A request offered while miss_ready is low is not captured.
//
//   Modports
//     master : the refill controller (drives miss_ready, the AHB request and the fill port)
//     slave  : the environment (miss logic, AHB slave, data array)
interface icache_refill_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  // miss request
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;

  // AHB-lite read master
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic              hwrite;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  // cache data array write port
  logic              fill_we;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              refill_done;
  logic              refill_err;

  modport master (
    input  miss_valid, miss_addr, hready, hresp, hrdata,
    output miss_ready, haddr, htrans, hburst, hsize, hwrite,
           fill_we, fill_idx, fill_data, refill_done, refill_err
  );

  modport slave (
    output miss_valid, miss_addr, hready, hresp, hrdata,
    input  miss_ready, haddr, htrans, hburst, hsize, hwrite,
           fill_we, fill_idx, fill_data, refill_done, refill_err
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//   AHB-lite read master that refills one I-cache line per miss. A miss
//   address is captured and aligned to the line, then a fixed-length
//   incrementing word burst is issued. Each returned beat is registered
//   and written into the cache data array one cycle after its data phase.
//   Only one refill is in flight at a time.
//
//   Ports
//     clk        clock, all state on posedge
//     rst        asynchronous reset, active-high
//     bus        icache_refill_if.master: miss handshake, AHB bus, fill port
//     state_dbg  current FSM state encoding (IDLE=0 ADDR=1 BURST=2 DRAIN=3 DONE=4 ERR=5)
module icache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  icache_refill_if.master       bus,
  output logic [2:0]            state_dbg
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  ALL_BEATS = CNT_W'(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  localparam logic [2:0] BURST_CODE = (LINE_WORDS == 4)  ? 3'b011 :
                                      (LINE_WORDS == 8)  ? 3'b101 :
                                      (LINE_WORDS == 16) ? 3'b111 : 3'b001;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  a_cnt_q;     // address phases issued
  logic [CNT_W-1:0]  d_cnt_q;     // data phases completed without error
  logic              dp_pend_q;   // a data phase is on the bus this cycle

  logic              fill_we_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [DATA_W-1:0] fill_data_q;

  logic [1:0]        htrans_c;
  logic [ADDR_W-1:0] haddr_c;
  logic              miss_ready_c;
  logic              done_c;
  logic              err_c;

  logic              accept;
  logic              dp_ok;
  logic              dp_err;

  assign accept = (state_q == S_IDLE) && bus.miss_valid;
  // An error response aborts on its first cycle, whether or not hready is
  // already high; the remaining beats of the line are never fetched.
  assign dp_err = dp_pend_q && bus.hresp;
  assign dp_ok  = dp_pend_q && bus.hready && !bus.hresp;

  // Next-state and bus outputs
  always_comb begin
    state_d      = state_q;
    htrans_c     = HT_IDLE;
    haddr_c      = '0;
    miss_ready_c = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        miss_ready_c = 1'b1;
        if (bus.miss_valid) state_d = S_ADDR;
      end
      S_ADDR: begin
        htrans_c = HT_NONSEQ;
        haddr_c  = base_q;
        if (bus.hready) state_d = S_BURST;
      end
      S_BURST: begin
        htrans_c = HT_SEQ;
        haddr_c  = base_q + (ADDR_W'(a_cnt_q) << 2);
        if (dp_err)                                     state_d = S_ERR;
        else if (bus.hready && (a_cnt_q == LAST_BEAT))  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once the last beat has been captured, so the done pulse
        // lands one cycle after the final fill write.
        if (dp_err)                      state_d = S_ERR;
        else if (d_cnt_q == ALL_BEATS)   state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      a_cnt_q     <= '0;
      d_cnt_q     <= '0;
      dp_pend_q   <= 1'b0;
      fill_we_q   <= 1'b0;
      fill_idx_q  <= '0;
      fill_data_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_we_q <= dp_ok;

      if (dp_ok) begin
        fill_idx_q  <= d_cnt_q[IDX_W-1:0];
        fill_data_q <= bus.hrdata;
        d_cnt_q     <= d_cnt_q + 1'b1;
      end

      // A data phase follows every address phase accepted with hready.
      // After an error nothing further is expected.
      if (dp_err || (state_q == S_ERR)) dp_pend_q <= 1'b0;
      else if (bus.hready)              dp_pend_q <= htrans_c[1];

      if (state_q == S_ADDR && bus.hready) a_cnt_q <= CNT_W'(1);
      else if (state_q == S_BURST && bus.hready && !dp_err) a_cnt_q <= a_cnt_q + 1'b1;

      if (accept) begin
        base_q  <= bus.miss_addr & LINE_MASK;
        a_cnt_q <= '0;
        d_cnt_q <= '0;
      end
    end
  end

  assign bus.miss_ready  = miss_ready_c;
  assign bus.htrans      = htrans_c;
  assign bus.haddr       = haddr_c;
  assign bus.hburst      = BURST_CODE;
  assign bus.hsize       = 3'b010;
  assign bus.hwrite      = 1'b0;
  assign bus.fill_we     = fill_we_q;
  assign bus.fill_idx    = fill_idx_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.refill_done = done_c;
  assign bus.refill_err  = err_c;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_refill_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) bus4 ();
  icache_refill_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) bus8 ();
  logic [2:0] st4, st8;

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus4), .state_dbg(st4)
  );
  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .state_dbg(st8)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic        mv;
    logic [31:0] maddr;
    logic        hr;
    logic        rsp;
    logic [31:0] rd;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic        e_we;
    logic [1:0]  e_idx;
    logic [31:0] e_data;
    logic        e_done;
    logic        e_err;
    logic        e_mr;
  } vec_t;

  vec_t vecs[$];

  // scoreboard for the back-to-back test
  logic [31:0] exp_q[$];
  logic [31:0] seen_q[$];
  int          ns_cyc[$];
  int          dn_cyc[$];
  int          mr_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic mv, input logic [31:0] ma, input logic hr, input logic rsp, input logic [31:0] rd,
    input logic [1:0] eh, input logic [31:0] ea, input logic ew, input logic [1:0] ei,
    input logic [31:0] ed, input logic edn, input logic eer, input logic emr);
    vec_t v;
    v.mv = mv; v.maddr = ma; v.hr = hr; v.rsp = rsp; v.rd = rd;
    v.e_htrans = eh; v.e_haddr = ea; v.e_we = ew; v.e_idx = ei; v.e_data = ed;
    v.e_done = edn; v.e_err = eer; v.e_mr = emr;
    return v;
  endfunction

  task automatic drive4(input logic mv, input logic [31:0] ma, input logic hr,
                        input logic rsp, input logic [31:0] rd);
    bus4.miss_valid = mv;
    bus4.miss_addr  = ma;
    bus4.hready     = hr;
    bus4.hresp      = rsp;
    bus4.hrdata     = rd;
  endtask

  // Each row is one clock cycle: inputs applied after the edge, outputs
  // sampled on the falling edge of the same cycle.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      drive4(v.mv, v.maddr, v.hr, v.rsp, v.rd);
      @(negedge clk);
      chk($sformatf("%s[%0d] htrans", tag, i), 32'(bus4.htrans), 32'(v.e_htrans));
      chk($sformatf("%s[%0d] haddr", tag, i), bus4.haddr, v.e_haddr);
      chk($sformatf("%s[%0d] fill_we", tag, i), 32'(bus4.fill_we), 32'(v.e_we));
      chk($sformatf("%s[%0d] refill_done", tag, i), 32'(bus4.refill_done), 32'(v.e_done));
      chk($sformatf("%s[%0d] refill_err", tag, i), 32'(bus4.refill_err), 32'(v.e_err));
      chk($sformatf("%s[%0d] miss_ready", tag, i), 32'(bus4.miss_ready), 32'(v.e_mr));
      if (v.e_we) begin
        chk($sformatf("%s[%0d] fill_idx", tag, i), 32'(bus4.fill_idx), 32'(v.e_idx));
        chk($sformatf("%s[%0d] fill_data", tag, i), bus4.fill_data, v.e_data);
      end
    end
    vecs.delete();
  endtask

  // Error-free 4-word refill with hready held high.
  task automatic push_clean(input logic [31:0] ma, input logic [31:0] db);
    logic [31:0] b;
    b = ma & ~32'hF;
    vecs.push_back(mk(1'b1, ma,    1'b1, 1'b0, 32'h0,    2'd0, 32'h0,    1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,    2'd2, b,        1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, db,       2'd3, b + 4,    1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, db + 1,   2'd3, b + 8,    1'b1, 2'd0, db,       1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, db + 2,   2'd3, b + 12,   1'b1, 2'd1, db + 1,   1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, db + 3,   2'd0, 32'h0,    1'b1, 2'd2, db + 2,   1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,    2'd0, 32'h0,    1'b1, 2'd3, db + 3,   1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,    2'd0, 32'h0,    1'b0, 2'd0, 32'h0,    1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,    2'd0, 32'h0,    1'b0, 2'd0, 32'h0,    1'b0, 1'b0, 1'b1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " htrans"},      32'(bus4.htrans), 32'h0);
    chk({tag, " haddr"},       bus4.haddr, 32'h0);
    chk({tag, " miss_ready"},  32'(bus4.miss_ready), 32'h1);
    chk({tag, " fill_we"},     32'(bus4.fill_we), 32'h0);
    chk({tag, " fill_idx"},    32'(bus4.fill_idx), 32'h0);
    chk({tag, " fill_data"},   bus4.fill_data, 32'h0);
    chk({tag, " refill_done"}, 32'(bus4.refill_done), 32'h0);
    chk({tag, " refill_err"},  32'(bus4.refill_err), 32'h0);
    chk({tag, " state"},       32'(st4), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive4(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    bus8.miss_valid = 1'b0;
    bus8.miss_addr  = 32'h0;
    bus8.hready     = 1'b1;
    bus8.hresp      = 1'b0;
    bus8.hrdata     = 32'h0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset hburst4", 32'(bus4.hburst), 32'h3);
    chk("reset hsize",   32'(bus4.hsize),  32'h2);
    chk("reset hwrite",  32'(bus4.hwrite), 32'h0);
    chk("reset hburst8", 32'(bus8.hburst), 32'h5);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- t1: zero-wait refill of 0x1234 ----
    vecs.push_back(mk(1'b1, 32'h1234, 1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd2, 32'h1230, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hDA7A0000, 2'd3, 32'h1234, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hDA7A0001, 2'd3, 32'h1238, 1'b1, 2'd0, 32'hDA7A0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hDA7A0002, 2'd3, 32'h123C, 1'b1, 2'd1, 32'hDA7A0001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hDA7A0003, 2'd0, 32'h0,    1'b1, 2'd2, 32'hDA7A0002, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b1, 2'd3, 32'hDA7A0003, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    run_vecs("t1");

    // ---- t2: two wait states on beat 2 data phase ----
    vecs.push_back(mk(1'b1, 32'h1234, 1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd2, 32'h1230, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hD0000000, 2'd3, 32'h1234, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hD0000001, 2'd3, 32'h1238, 1'b1, 2'd0, 32'hD0000000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 32'hBAD0BAD0, 2'd3, 32'h123C, 1'b1, 2'd1, 32'hD0000001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 32'hBAD0BAD1, 2'd3, 32'h123C, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hD0000002, 2'd3, 32'h123C, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hD0000003, 2'd0, 32'h0,    1'b1, 2'd2, 32'hD0000002, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b1, 2'd3, 32'hD0000003, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    run_vecs("t2");

    // ---- t3: error response on beat 1 ----
    vecs.push_back(mk(1'b1, 32'h4008, 1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd2, 32'h4000, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hE0000000, 2'd3, 32'h4004, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b1, 32'hE0000001, 2'd3, 32'h4008, 1'b1, 2'd0, 32'hE0000000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hE0000002, 2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'hE0000003, 2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        2'd0, 32'h0,    1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1));
    run_vecs("t3");

    // ---- t4: reset in the middle of a burst ----
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      drive4((c == 0), 32'h1234, 1'b1, 1'b0, 32'h77000000 + 32'(c));
      @(negedge clk);
    end
    chk("t4 pre-reset fill_we",  32'(bus4.fill_we), 32'h1);
    chk("t4 pre-reset fill_idx", 32'(bus4.fill_idx), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t4 in-reset");
    @(posedge clk); #1;
    rst = 1'b0;
    drive4(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    push_clean(32'h8888, 32'hF0000000);
    run_vecs("t4");

    // ---- t5: back-to-back misses, request held valid while busy ----
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h2F0);
    mr_busy = 0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      drive4((c < 16), (c == 0) ? 32'h100 : 32'h2F0, 1'b1, 1'b0, 32'h55000000 + 32'(c));
      @(negedge clk);
      if (bus4.htrans == 2'b10) begin
        seen_q.push_back(bus4.haddr);
        ns_cyc.push_back(c);
      end
      if (bus4.refill_done) dn_cyc.push_back(c);
      if (c >= 1 && c <= 7 && bus4.miss_ready) mr_busy++;
    end
    chk("t5 burst count", 32'(seen_q.size()), 32'd2);
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("t5 base[%0d]", k), (k < seen_q.size()) ? seen_q[k] : 32'hFFFFFFFF, exp_q[k]);
      chk($sformatf("t5 nonseq cycle[%0d]", k), (k < ns_cyc.size()) ? 32'(ns_cyc[k]) : 32'hFFFFFFFF, 32'(1 + 8 * k));
      chk($sformatf("t5 done cycle[%0d]", k), (k < dn_cyc.size()) ? 32'(dn_cyc[k]) : 32'hFFFFFFFF, 32'(7 + 8 * k));
    end
    chk("t5 done count", 32'(dn_cyc.size()), 32'd2);
    chk("t5 miss_ready while busy", 32'(mr_busy), 32'd0);

    // ---- t6: 8-word line ----
    for (int c = 0; c < 14; c++) begin
      logic [1:0]  eh;
      logic [31:0] ea;
      logic        ew;
      @(posedge clk); #1;
      bus8.miss_valid = (c == 0);
      bus8.miss_addr  = 32'h5A34;
      bus8.hready     = 1'b1;
      bus8.hresp      = 1'b0;
      bus8.hrdata     = (c >= 2 && c <= 9) ? 32'hC0000000 + 32'(c - 2) : 32'h0;
      @(negedge clk);
      eh = (c == 1) ? 2'b10 : (c >= 2 && c <= 8) ? 2'b11 : 2'b00;
      ea = (c == 1) ? 32'h5A20 : (c >= 2 && c <= 8) ? 32'h5A20 + 32'(4 * (c - 1)) : 32'h0;
      ew = (c >= 3 && c <= 10);
      chk($sformatf("t6[%0d] htrans", c),  32'(bus8.htrans), 32'(eh));
      chk($sformatf("t6[%0d] haddr", c),   bus8.haddr, ea);
      chk($sformatf("t6[%0d] fill_we", c), 32'(bus8.fill_we), 32'(ew));
      if (ew) begin
        chk($sformatf("t6[%0d] fill_idx", c),  32'(bus8.fill_idx), 32'(c - 3));
        chk($sformatf("t6[%0d] fill_data", c), bus8.fill_data, 32'hC0000000 + 32'(c - 3));
      end
      chk($sformatf("t6[%0d] refill_done", c), 32'(bus8.refill_done), 32'(c == 11));
    end
    chk("t6 hburst", 32'(bus8.hburst), 32'h5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
